busca_binaria: RTL and testbench
================================

# busca_binaria

Sequential binary-search controller that drives the A side of an external combinational `ComparadorMagnitude` and reads back its `aeqb`/`agtb`/`altb` flags to discover the unknown value applied to that comparator's B input. It sits opposite the comparator: this block issues a candidate, the comparator responds, and the FSM narrows the interval until equality is found. Used for auto-calibration and threshold discovery in the comparator data path.

## Interface

Parameters:
- `WIDTH`, 4, data width of the candidate, result and comparator operands

Ports:
- `clk`  input  1  system clock, all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request a new search; sampled only in IDLE
- `aeqb`  input  1  comparator flag: candidate == secret
- `agtb`  input  1  comparator flag: candidate > secret
- `altb`  input  1  comparator flag: candidate < secret
- `a`  output  WIDTH  candidate driven to the comparator A input
- `busy`  output  1  high while in PROBE
- `done`  output  1  one-cycle pulse in DONE
- `found`  output  1  search ended on equality; held until next accepted `start`
- `err`  output  1  inconsistent flags seen; held until next accepted `start`
- `result`  output  WIDTH  value found; held until next accepted `start`
- `probes`  output  $clog2(WIDTH+2)  number of probe cycles used by the last/current search

## Operation

- FSM states: IDLE, PROBE, DONE. Reset -> IDLE.
- Interval registers `lo`, `hi` are WIDTH+1 bits wide (no wrap). On accepted `start`: `lo`=0, `hi`=2^WIDTH-1, `probes`=0, `found`/`err`/`result` cleared, -> PROBE.
- In PROBE: `a` = (`lo`+`hi`)>>1, computed in WIDTH+1 bits, truncated to WIDTH. In IDLE and DONE, `a`=0.
- Each PROBE cycle samples flags at the rising edge and increments `probes`:
  - exactly `aeqb`: `result`=`a`, `found`=1, -> DONE
  - exactly `agtb`: `hi`=`a`-1 (WIDTH+1-bit arithmetic, so `a`=0 gives -1 / all ones in WIDTH+1 bits); compare for empty below
  - exactly `altb`: `lo`=`a`+1 (`a`=max gives 2^WIDTH)
  - zero flags or more than one flag: `err`=1, `found`=0, -> DONE
- Empty interval: if the updated `lo` > updated `hi` (unsigned, WIDTH+1 bits; treat `hi`=-1 as empty), `found`=0, `err`=0, -> DONE.
- DONE lasts exactly one cycle, then -> IDLE unconditionally.
- `start` in PROBE or DONE is ignored. `start` held high in IDLE after DONE starts a new search.
- With a consistent comparator and any secret in 0..2^WIDTH-1, search always ends with `found`=1 within WIDTH+1 probes.

## Timing

- Reset values: `a`=0, `busy`=0, `done`=0, `found`=0, `err`=0, `result`=0, `probes`=0, state IDLE.
- Asynchronous `rst` mid-search aborts immediately to reset values; no partial result survives.
- `start` sampled at edge E0 -> `busy`=1 and first candidate on `a` after E0. The comparator is combinational, so flags are valid in the same cycle.
- Probe k is sampled at edge Ek. The final probe at Ek -> `done`=1 and `busy`=0 for the cycle after Ek. Latency from start to done = probes + 1 edges.
- `result`, `found`, `err` and `probes` are valid from the `done` cycle and stable until the next accepted `start`.
- Worst case for WIDTH=4 is 5 probes; `done` is then high after E5.

## Test plan

- Secret 7, WIDTH=4, pulse `start` -> `a`=7 in the first probe; `done` after E1, `found`=1, `result`=7, `probes`=1.
- Secret 15 -> `a` sequence 7, 11, 13, 14, 15; `done` after E5, `found`=1, `result`=15, `probes`=5 (upper boundary, `lo` reaches 15 without wrap).
- Secret 0 -> `a` sequence 7, 3, 1, 0; `found`=1, `result`=0, `probes`=4.
- Comparator emulated with secret 16 (always `altb`) -> `a` sequence 7, 11, 13, 14, 15, then `lo`=16 > `hi`=15; `done` with `found`=0, `err`=0, `probes`=5.
- Force `aeqb`=`agtb`=1 in the first probe -> `done` after E1, `err`=1, `found`=0. Then `start` again with a consistent comparator and secret 5 -> `err` clears, `found`=1, `result`=5.
- Secret 12: assert `rst` after E2 -> all outputs return to reset values immediately, state IDLE. `start` pulses during PROBE are ignored (`a` sequence and `probes` unchanged).

Source files
------------

// File: rtl/busca_binaria.sv
// Binary-search controller: drives candidate `a` into an external magnitude
// comparator and narrows [lo, hi] from its flags until equality is found.
module busca_binaria #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         aeqb,
    input  logic                         agtb,
    input  logic                         altb,
    output logic [WIDTH-1:0]             a,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic                         err,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+2)-1:0]   probes,
    output logic [1:0]                   state_dbg
);

    localparam int PW = $clog2(WIDTH+2);
    localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ALL_ONE = {(WIDTH+1){1'b1}};
    localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, nxt_state;
    logic [WIDTH:0]    lo, hi, nxt_lo, nxt_hi;
    logic [WIDTH:0]    cand, hi_dec, lo_inc;
    logic [PW-1:0]     nxt_probes;
    logic              nxt_found, nxt_err;
    logic [WIDTH-1:0]  nxt_result;

    // lo <= 2^WIDTH and hi <= 2^WIDTH-1, so lo+hi never overflows WIDTH+1 bits.
    assign cand   = (state == PROBE) ? ((lo + hi) >> 1) : '0;
    assign a      = cand[WIDTH-1:0];
    assign hi_dec = cand - ONE;
    assign lo_inc = cand + ONE;

    assign busy      = (state == PROBE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '0;
            probes <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state  <= nxt_state;
            lo     <= nxt_lo;
            hi     <= nxt_hi;
            probes <= nxt_probes;
            found  <= nxt_found;
            err    <= nxt_err;
            result <= nxt_result;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_lo     = lo;
        nxt_hi     = hi;
        nxt_probes = probes;
        nxt_found  = found;
        nxt_err    = err;
        nxt_result = result;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_lo     = '0;
                    nxt_hi     = HI_INIT;
                    nxt_probes = '0;
                    nxt_found  = 1'b0;
                    nxt_err    = 1'b0;
                    nxt_result = '0;
                    nxt_state  = PROBE;
                end
            end
            PROBE: begin
                nxt_probes = probes + PW'(1);
                case ({aeqb, agtb, altb})
                    3'b100: begin
                        nxt_result = a;
                        nxt_found  = 1'b1;
                        nxt_state  = DONE;
                    end
                    3'b010: begin
                        nxt_hi = hi_dec;
                        // hi_dec of all ones means a was 0: nothing left below it
                        if (hi_dec == ALL_ONE || lo > hi_dec) nxt_state = DONE;
                    end
                    3'b001: begin
                        nxt_lo = lo_inc;
                        if (lo_inc > hi) nxt_state = DONE;
                    end
                    default: begin
                        nxt_err   = 1'b1;
                        nxt_found = 1'b0;
                        nxt_state = DONE;
                    end
                endcase
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_busca_binaria.sv
// Directed bench for busca_binaria: a behavioural comparator answers the
// candidate, expected candidate sequences are queued and checked per probe.
module tb_busca_binaria;

    localparam int W  = 4;
    localparam int PW = $clog2(W+2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          aeqb, agtb, altb;
    logic [W-1:0]  a;
    logic          busy, done, found, err;
    logic [W-1:0]  result;
    logic [PW-1:0] probes;
    logic [1:0]    state_dbg;

    int            secret;
    bit            force_bad;
    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    busca_binaria #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .aeqb(aeqb), .agtb(agtb), .altb(altb),
        .a(a), .busy(busy), .done(done), .found(found), .err(err),
        .result(result), .probes(probes), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Comparator model: B = secret (may be out of range), or a broken flag set.
    always_comb begin
        aeqb = 1'b0;
        agtb = 1'b0;
        altb = 1'b0;
        if (force_bad) begin
            aeqb = 1'b1;
            agtb = 1'b1;
        end else if (int'(a) == secret) aeqb = 1'b1;
        else if (int'(a) > secret)      agtb = 1'b1;
        else                            altb = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller loads exp_q with the candidate sequence before calling.
    task automatic run_search(input int sec, input bit bad, input bit spam,
                              input int exp_probes, input bit exp_found,
                              input bit exp_err, input int exp_result);
        int edges;
        bit got_done;
        secret    = sec;
        force_bad = bad;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        edges    = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) begin
                    if (exp_q.size() > 0) check("a_seq", 32'(a), 32'(exp_q.pop_front()));
                    else                  check("extra_probe", 32'(busy), 32'd0);
                    if (spam) start = 1'b1;
                end
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                edges++;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("latency", 32'(edges), 32'(exp_probes));
        check("found", 32'(found), 32'(exp_found));
        check("err", 32'(err), 32'(exp_err));
        check("result", 32'(result), 32'(exp_result));
        check("probes", 32'(probes), 32'(exp_probes));
        check("busy_in_done", 32'(busy), 32'd0);
        check("seq_consumed", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("back_idle", 32'(state_dbg), 32'd0);
        check("result_hold", 32'(result), 32'(exp_result));
        check("found_hold", 32'(found), 32'(exp_found));
        exp_q.delete();
        force_bad = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        secret    = 0;
        force_bad = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", 32'(a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_probes", 32'(probes), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        exp_q = '{4'd7};
        run_search(7, 1'b0, 1'b0, 1, 1'b1, 1'b0, 7);

        exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search(15, 1'b0, 1'b0, 5, 1'b1, 1'b0, 15);

        exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
        run_search(0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 0);

        // Secret above range: always altb, lo runs past hi without wrapping.
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search(16, 1'b0, 1'b0, 5, 1'b0, 1'b0, 0);

        exp_q = '{4'd7};
        run_search(5, 1'b1, 1'b0, 1, 1'b0, 1'b1, 0);

        exp_q = '{4'd7, 4'd3, 4'd5};
        run_search(5, 1'b0, 1'b0, 3, 1'b1, 1'b0, 5);

        // Asynchronous reset in the middle of a search.
        secret = 12;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("mid_a0", 32'(a), 32'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_a2", 32'(a), 32'd13);
        check("mid_probes", 32'(probes), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_a", 32'(a), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_probes", 32'(probes), 32'd0);
        check("arst_state", 32'(state_dbg), 32'd0);
        check("arst_found", 32'(found), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start pulses while probing must not disturb the search.
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd12};
        run_search(12, 1'b0, 1'b1, 4, 1'b1, 1'b0, 12);

        // start held high straight through DONE relaunches from IDLE.
        secret = 3;
        start  = 1'b1;
        begin
            bit relaunched = 1'b0;
            for (int cyc = 0; cyc < 20 && !relaunched; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("held_idle", 32'(state_dbg), 32'd0);
                    @(posedge clk);
                    @(negedge clk);
                    check("held_relaunch", 32'(busy), 32'd1);
                    check("held_first_a", 32'(a), 32'd7);
                    check("held_probes_clr", 32'(probes), 32'd0);
                    relaunched = 1'b1;
                end
            end
            check("held_seen", 32'(relaunched), 32'd1);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
